// File: rtl/bnn_tx_pkg.sv
// bnn_tx_pkg: shared definitions for the BNN bit-serial load transmitter.
//   - tx_state_e : transmitter FSM states
//   - *_PIN      : bit positions of mode / pixel / weight pins on ui_in[]
//   - pix_bytes(), wgt_bytes() : byte counts per frame for a given bit count
package bnn_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_LEAD,
        ST_SEND,
        ST_DONE,
        ST_ERR
    } tx_state_e;

    localparam int MODE_PIN     = 0;
    localparam int PIX_PIN      = 1;
    localparam int WGT_PIN      = 2;

    localparam int BYTE_W       = 8;
    localparam int PIX_BITS_DEF = 784;
    localparam int WGT_BITS_DEF = 2320;

    function automatic int pix_bytes(input int bits);
        return bits / BYTE_W;
    endfunction

    function automatic int wgt_bytes(input int bits);
        return bits / BYTE_W;
    endfunction

endpackage

// File: rtl/bnn_tx_lane.sv
// bnn_tx_lane: one serial lane of the load transmitter.
//   A 1-byte holding buffer fed by a valid/ready byte stream, an 8-bit shift register
//   that emits MSB first, and a count of bytes accepted/loaded for the current frame.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (flushes buffers)
//   clr_i          start of frame: flush buffers and byte counters
//   en_i           stream acceptance enabled (frame in progress)
//   load_i         move the first byte from hold into the shift register
//   shift_i        one bit goes out this cycle
//   data_i/valid_i/ready_o   byte stream
//   hold_full_o    holding buffer occupied
//   bit_o          current serial bit (0 once the lane has no data left)
//   underflow_o    a reload is due this cycle but the hold buffer is empty
module bnn_tx_lane
    import bnn_tx_pkg::*;
#(
    parameter int NBYTES = 98
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              hold_full_o,
    output logic              bit_o,
    output logic              underflow_o
);

    localparam int            CW = $clog2(NBYTES + 1);
    localparam logic [CW-1:0] NB = CW'(NBYTES);

    logic [BYTE_W-1:0] hold_q, hold_d;
    logic [BYTE_W-1:0] sh_q, sh_d;
    logic              hold_full_q, hold_full_d;
    logic              sh_vld_q, sh_vld_d;
    logic [2:0]        pos_q, pos_d;
    logic [CW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     ld_q, ld_d;
    logic              accept, reload, take;

    assign ready_o     = en_i && !hold_full_q && (acc_q < NB);
    assign accept      = valid_i && ready_o;
    // A reload is due when the 8th bit leaves and the frame still has bytes to load.
    assign reload      = shift_i && sh_vld_q && (pos_q == 3'd7) && (ld_q < NB);
    assign underflow_o = reload && !hold_full_q;
    assign take        = hold_full_q && (load_i || reload);
    assign hold_full_o = hold_full_q;
    assign bit_o       = sh_vld_q && sh_q[BYTE_W-1];

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sh_d        = sh_q;
        sh_vld_d    = sh_vld_q;
        pos_d       = pos_q;
        acc_d       = acc_q;
        ld_d        = ld_q;
        if (clr_i) begin
            hold_full_d = 1'b0;
            sh_vld_d    = 1'b0;
            pos_d       = 3'd0;
            acc_d       = '0;
            ld_d        = '0;
        end else begin
            if (shift_i && sh_vld_q) begin
                sh_d  = {sh_q[BYTE_W-2:0], 1'b0};
                pos_d = pos_q + 3'd1;
                if (pos_q == 3'd7) begin
                    sh_vld_d = 1'b0;
                end
            end
            // Reload reads the old hold value; a byte accepted the same cycle refills hold.
            if (take) begin
                sh_d        = hold_q;
                sh_vld_d    = 1'b1;
                pos_d       = 3'd0;
                ld_d        = ld_q + CW'(1);
                hold_full_d = 1'b0;
            end
            if (accept) begin
                hold_d      = data_i;
                hold_full_d = 1'b1;
                acc_d       = acc_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_full_q <= 1'b0;
            sh_vld_q    <= 1'b0;
            pos_q       <= 3'd0;
            acc_q       <= '0;
            ld_q        <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            sh_vld_q    <= sh_vld_d;
            pos_q       <= pos_d;
            acc_q       <= acc_d;
            ld_q        <= ld_d;
        end
        hold_q <= hold_d;
        sh_q   <= sh_d;
    end

endmodule

// File: rtl/bnn_load_tx.sv
// bnn_load_tx: host-side serializer for the BNN bit-serial load interface.
//   Accepts pixel and weight bytes on two valid/ready streams and drives the chip's
//   ui_in[0] (mode), ui_in[1] (pixel bit) and ui_in[2] (weight bit), one bit per lane per clk.
// Ports:
//   clk, reset (sync, active-high), start (frame request, honoured only when idle)
//   pix_data/pix_valid/pix_ready, wgt_data/wgt_valid/wgt_ready : byte streams, MSB first
//   mode_o, pix_bit_o, wgt_bit_o : registered load pins
//   busy (PRIME/LEAD/SEND), done (1-cycle pulse), underflow (sticky), bit_cnt (weight bits sent)
// Optional build macro BNN_TX_CHECKSUM_EN adds pix_ones[9:0] / wgt_ones[11:0]: popcount of
//   data bits sent this frame, cleared at start, valid with done.
module bnn_load_tx
    import bnn_tx_pkg::*;
#(
    parameter int PIX_BITS = PIX_BITS_DEF,
    parameter int WGT_BITS = WGT_BITS_DEF,
    parameter int LEAD     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  wgt_data,
    input  logic        wgt_valid,
    output logic        wgt_ready,
    output logic        mode_o,
    output logic        pix_bit_o,
    output logic        wgt_bit_o,
    output logic        busy,
    output logic        done,
    output logic        underflow,
    output logic [11:0] bit_cnt
`ifdef BNN_TX_CHECKSUM_EN
    ,
    output logic [9:0]  pix_ones,
    output logic [11:0] wgt_ones
`endif
);

    localparam int             LCW       = (LEAD > 1) ? $clog2(LEAD) : 1;
    localparam logic [LCW-1:0] LEAD_LAST = LCW'(LEAD - 1);
    localparam logic [11:0]    WGT_MAX   = 12'(WGT_BITS);

    tx_state_e      state_q, state_d;
    logic [LCW-1:0] lead_q, lead_d;
    logic [11:0]    bitcnt_q, bitcnt_d;
    logic [2:0]     pins_q, pins_d;
    logic           done_q, done_d;
    logic           unf_q, unf_d;

    logic lane_clr, lane_en, lane_load, lane_shift;
    logic pix_full, wgt_full, pix_bit, wgt_bit, pix_unf, wgt_unf;

    bnn_tx_lane #(.NBYTES(pix_bytes(PIX_BITS))) u_pix (
        .clk_i      (clk),
        .rst_i      (reset),
        .clr_i      (lane_clr),
        .en_i       (lane_en),
        .load_i     (lane_load),
        .shift_i    (lane_shift),
        .data_i     (pix_data),
        .valid_i    (pix_valid),
        .ready_o    (pix_ready),
        .hold_full_o(pix_full),
        .bit_o      (pix_bit),
        .underflow_o(pix_unf)
    );

    bnn_tx_lane #(.NBYTES(wgt_bytes(WGT_BITS))) u_wgt (
        .clk_i      (clk),
        .rst_i      (reset),
        .clr_i      (lane_clr),
        .en_i       (lane_en),
        .load_i     (lane_load),
        .shift_i    (lane_shift),
        .data_i     (wgt_data),
        .valid_i    (wgt_valid),
        .ready_o    (wgt_ready),
        .hold_full_o(wgt_full),
        .bit_o      (wgt_bit),
        .underflow_o(wgt_unf)
    );

    // Pins are registered from the current state, so they trail the state by one clk.
    always_comb begin
        state_d    = state_q;
        lead_d     = lead_q;
        bitcnt_d   = bitcnt_q;
        pins_d     = 3'b000;
        done_d     = 1'b0;
        unf_d      = unf_q;
        lane_clr   = 1'b0;
        lane_en    = 1'b0;
        lane_load  = 1'b0;
        lane_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_PRIME;
                    unf_d    = 1'b0;
                    bitcnt_d = 12'd0;
                    lane_clr = 1'b1;
                end
            end
            ST_PRIME: begin
                lane_en = 1'b1;
                if (pix_full && wgt_full) begin
                    lane_load = 1'b1;
                    lead_d    = '0;
                    state_d   = ST_LEAD;
                end
            end
            ST_LEAD: begin
                lane_en          = 1'b1;
                pins_d[MODE_PIN] = 1'b1;
                if (lead_q == LEAD_LAST) begin
                    state_d = ST_SEND;
                end else begin
                    lead_d = lead_q + LCW'(1);
                end
            end
            ST_SEND: begin
                lane_en    = 1'b1;
                lane_shift = 1'b1;
                if (pix_unf || wgt_unf) begin
                    // The starved bit is not sent: pins drop together with underflow.
                    unf_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    pins_d[MODE_PIN] = 1'b1;
                    pins_d[PIX_PIN]  = pix_bit;
                    pins_d[WGT_PIN]  = wgt_bit;
                    if (bitcnt_q < WGT_MAX) begin
                        bitcnt_d = bitcnt_q + 12'd1;
                    end
                    if (bitcnt_q == WGT_MAX - 12'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            lead_q   <= '0;
            bitcnt_q <= 12'd0;
            pins_q   <= 3'b000;
            done_q   <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lead_q   <= lead_d;
            bitcnt_q <= bitcnt_d;
            pins_q   <= pins_d;
            done_q   <= done_d;
            unf_q    <= unf_d;
        end
    end

    assign mode_o    = pins_q[MODE_PIN];
    assign pix_bit_o = pins_q[PIX_PIN];
    assign wgt_bit_o = pins_q[WGT_PIN];
    assign busy      = (state_q == ST_PRIME) || (state_q == ST_LEAD) || (state_q == ST_SEND);
    assign done      = done_q;
    assign underflow = unf_q;
    assign bit_cnt   = bitcnt_q;

`ifdef BNN_TX_CHECKSUM_EN
    logic [9:0]  pones_q, pones_d;
    logic [11:0] wones_q, wones_d;

    // Counts only bits actually driven as data; lead and pad cycles carry 0 anyway.
    always_comb begin
        pones_d = pones_q;
        wones_d = wones_q;
        if ((state_q == ST_IDLE) && start) begin
            pones_d = 10'd0;
            wones_d = 12'd0;
        end else if ((state_q == ST_SEND) && !(pix_unf || wgt_unf)) begin
            pones_d = pones_q + 10'(pix_bit);
            wones_d = wones_q + 12'(wgt_bit);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pones_q <= 10'd0;
            wones_q <= 12'd0;
        end else begin
            pones_q <= pones_d;
            wones_q <= wones_d;
        end
    end

    assign pix_ones = pones_q;
    assign wgt_ones = wones_q;
`endif

endmodule

// File: tb/tb_bnn_load_tx.sv
// tb_bnn_load_tx: self-checking bench for bnn_load_tx.
//   A table of frame records (byte patterns, valid-gap mode, restart flag, expected
//   done/underflow) is run in a loop; accepted bytes are pushed bit by bit into
//   scoreboard queues and popped as the pins toggle. Reset state and mid-frame reset
//   are hand-written sequences. Define BNN_TX_CHECKSUM_EN to also check popcounts.
module tb_bnn_load_tx;

    localparam int PIX_BITS  = 784;
    localparam int WGT_BITS  = 2320;
    localparam int LEAD      = 1;
    localparam int PIX_BYTES = PIX_BITS / 8;
    localparam int WGT_BYTES = WGT_BITS / 8;
    localparam int BUDGET    = 4000;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [7:0]  pix_data, wgt_data;
    logic        pix_valid, wgt_valid, pix_ready, wgt_ready;
    logic        mode_o, pix_bit_o, wgt_bit_o, busy, done, underflow;
    logic [11:0] bit_cnt;
`ifdef BNN_TX_CHECKSUM_EN
    logic [9:0]  pix_ones;
    logic [11:0] wgt_ones;
`endif

    always #5 clk = ~clk;

    bnn_load_tx dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pix_data (pix_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .wgt_data (wgt_data),
        .wgt_valid(wgt_valid),
        .wgt_ready(wgt_ready),
        .mode_o   (mode_o),
        .pix_bit_o(pix_bit_o),
        .wgt_bit_o(wgt_bit_o),
        .busy     (busy),
        .done     (done),
        .underflow(underflow),
        .bit_cnt  (bit_cnt)
`ifdef BNN_TX_CHECKSUM_EN
        ,
        .pix_ones (pix_ones),
        .wgt_ones (wgt_ones)
`endif
    );

    typedef struct {
        logic [7:0] pix_base;
        bit         pix_inc;
        logic [7:0] wgt_base;
        bit         wgt_inc;
        int         gap_mode;   // 0 always valid, 1 random gaps, 2 long weight gap at byte 100
        bit         restart;    // pulse start again in the middle of SEND
        int         exp_done;
        int         exp_unf;
    } vec_t;

    vec_t vecs[7];
    int   errors = 0;
    int   checks = 0;
    bit   exp_pix[$];
    bit   exp_wgt[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [7:0] base, input bit inc, input int idx);
        return inc ? base + 8'(idx) : base;
    endfunction

    function automatic int ones_of(input logic [7:0] base, input bit inc, input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += $countones(byte_of(base, inc, i));
        return s;
    endfunction

    task automatic run_frame(input vec_t v, input int abort_at, output bit aborted);
        int pidx = 0, widx = 0, pgap = 0, wgap = 0;
        int mode_cnt = 0, rises = 0, dones = 0, mism = 0, cyc = 0, post = -1, j = 0;
        bit pa, wa, prev_mode = 1'b0, gap2_done = 1'b0, ended = 1'b0;
        exp_pix.delete();
        exp_wgt.delete();
        aborted   = 1'b0;
        start     = 1'b1;
        pix_valid = 1'b0;
        wgt_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_clears_underflow", underflow, 0);
        check("busy_after_start", busy, 1);
        check("bit_cnt_cleared", bit_cnt, 0);
        check("pix_ready_prime", pix_ready, 1);
        check("wgt_ready_prime", wgt_ready, 1);
        pix_valid = 1'b1;
        pix_data  = byte_of(v.pix_base, v.pix_inc, 0);
        wgt_valid = 1'b1;
        wgt_data  = byte_of(v.wgt_base, v.wgt_inc, 0);
        while (!ended) begin
            pa = pix_valid && pix_ready;
            wa = wgt_valid && wgt_ready;
            @(posedge clk); #1;
            cyc++;
            if (pa) begin
                for (int b = 7; b >= 0; b--) exp_pix.push_back(pix_data[b]);
                pidx++;
                pgap = (v.gap_mode == 1) ? int'($urandom_range(0, 3)) : 0;
            end
            if (wa) begin
                for (int b = 7; b >= 0; b--) exp_wgt.push_back(wgt_data[b]);
                widx++;
                wgap = (v.gap_mode == 1) ? int'($urandom_range(0, 3)) : 0;
            end
            // Scoreboard: lead cycles carry zeros, then one queued bit per lane per cycle.
            if (mode_o) begin
                if (!prev_mode) rises++;
                if (mode_cnt < LEAD) begin
                    if (pix_bit_o || wgt_bit_o) mism++;
                end else begin
                    j = mode_cnt - LEAD;
                    if (exp_wgt.size() == 0) mism++;
                    else if (exp_wgt.pop_front() != wgt_bit_o) mism++;
                    if (j < PIX_BITS) begin
                        if (exp_pix.size() == 0) mism++;
                        else if (exp_pix.pop_front() != pix_bit_o) mism++;
                    end else if (pix_bit_o) begin
                        mism++;
                    end
                end
                mode_cnt++;
            end else if (pix_bit_o || wgt_bit_o) begin
                mism++;
            end
            prev_mode = mode_o;
            if (done) dones++;
            if (abort_at >= 0 && mode_cnt - LEAD == abort_at) begin
                aborted = 1'b1;
                ended   = 1'b1;
            end
            if (post < 0) begin
                if (done || underflow) post = 3;
            end else begin
                post--;
            end
            if (post == 0 || cyc >= BUDGET) ended = 1'b1;
            if (v.gap_mode == 2 && widx == 100 && !gap2_done && wgt_ready) begin
                wgap      = 12;
                gap2_done = 1'b1;
            end
            pix_valid = (pidx < PIX_BYTES) && (pgap == 0);
            pix_data  = byte_of(v.pix_base, v.pix_inc, pidx);
            wgt_valid = (widx < WGT_BYTES) && (wgap == 0);
            wgt_data  = byte_of(v.wgt_base, v.wgt_inc, widx);
            if (pgap > 0) pgap--;
            if (wgap > 0) wgap--;
            start = (v.restart && mode_cnt == 1000) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        if (aborted) return;
        pix_valid = 1'b0;
        wgt_valid = 1'b0;
        check("frame_ended_in_budget", int'(post == 0), 1);
        check("trace_mismatches", mism, 0);
        check("done_pulses", dones, v.exp_done);
        check("underflow_flag", underflow, v.exp_unf);
        check("bit_cnt_vs_data_cycles", bit_cnt, (mode_cnt > LEAD) ? mode_cnt - LEAD : 0);
        check("busy_after_frame", busy, 0);
        check("mode_low_after_frame", mode_o, 0);
        if (v.exp_done != 0) begin
            check("mode_high_cycles", mode_cnt, LEAD + WGT_BITS);
            check("mode_contiguous", rises, 1);
            check("bit_cnt_final", bit_cnt, WGT_BITS);
`ifdef BNN_TX_CHECKSUM_EN
            check("pix_ones", pix_ones, ones_of(v.pix_base, v.pix_inc, PIX_BYTES));
            check("wgt_ones", wgt_ones, ones_of(v.wgt_base, v.wgt_inc, WGT_BYTES));
`endif
        end
    endtask

    initial begin
        bit ab;
        //          pix    inc   wgt    inc   gap restart done unf
        vecs[0] = '{8'hA5, 1'b0, 8'h3C, 1'b0, 0, 1'b0, 1, 0};
        vecs[1] = '{8'hA5, 1'b0, 8'h3C, 1'b0, 1, 1'b0, 1, 0};
        vecs[2] = '{8'hA5, 1'b0, 8'h3C, 1'b0, 2, 1'b0, 0, 1};
        vecs[3] = '{8'hA5, 1'b0, 8'h3C, 1'b0, 0, 1'b1, 1, 0};
        vecs[4] = '{8'hFF, 1'b0, 8'h01, 1'b0, 0, 1'b0, 1, 0};
        vecs[5] = '{8'h00, 1'b1, 8'h80, 1'b1, 1, 1'b0, 1, 0};
        vecs[6] = '{8'h5A, 1'b0, 8'hFF, 1'b0, 0, 1'b0, 1, 0};

        reset     = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        wgt_valid = 1'b0;
        pix_data  = 8'h00;
        wgt_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mode", mode_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_underflow", underflow, 0);
        check("rst_bit_cnt", bit_cnt, 0);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_wgt_ready", wgt_ready, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i], -1, ab);
            repeat (2) @(posedge clk);
            #1;
        end

        // Reset in the middle of SEND, then make sure the lanes stay closed until start.
        run_frame(vecs[0], 500, ab);
        check("abort_point_reached", ab, 1);
        check("bit_cnt_at_abort", bit_cnt, 500);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_mode", mode_o, 0);
        check("midrst_busy", busy, 0);
        check("midrst_bit_cnt", bit_cnt, 0);
        check("midrst_pix_ready", pix_ready, 0);
        check("midrst_wgt_ready", wgt_ready, 0);
        pix_valid = 1'b1;
        wgt_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_pix_ready_low", pix_ready, 0);
        check("idle_wgt_ready_low", wgt_ready, 0);
        check("idle_mode_low", mode_o, 0);
        pix_valid = 1'b0;
        wgt_valid = 1'b0;
        run_frame(vecs[0], -1, ab);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
